// File: rtl/ctrl_pkg.sv
// Shared state type, instruction encodings and decoded-instruction record
// for the datapath sequencer.
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_WAIT   = 3'd0,
        S_DECODE = 3'd1,
        S_WR_IMM = 3'd2,
        S_GET_A  = 3'd3,
        S_GET_B  = 3'd4,
        S_EXEC   = 3'd5,
        S_WR_RES = 3'd6
    } ctrl_state_t;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_CMP  = 2'b01;
    localparam logic [1:0] OP_AND  = 2'b10;
    localparam logic [1:0] OP_MVN  = 2'b11;
    localparam logic [1:0] OP_MOVI = 2'b10;
    localparam logic [1:0] OP_MOVR = 2'b00;

    // MOV reg is executed as 0 + shifted Rm, so it uses the ADD opcode with asel
    localparam logic [1:0] ALU_PASS = 2'b00;

    typedef struct packed {
        logic [2:0] rn;
        logic [2:0] rd;
        logic [2:0] rm;
        logic [1:0] op;
        logic [1:0] sh;
        logic       is_movi;
        logic       is_movr;
        logic       is_mvn;
        logic       is_cmp;
        logic       is_abin;   // ADD/CMP/AND: needs the Rn operand in A
        logic       illegal;
    } ins_fields_t;

endpackage

// File: rtl/ins_decoder.sv
// Combinational instruction decoder: field extraction, class flags and
// sign-extension of imm8 to the datapath width.
module ins_decoder
    import ctrl_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [15:0]       ir,
    output ins_fields_t       fields,
    output logic [DATA_W-1:0] imm_ext
);

    assign imm_ext = {{(DATA_W-8){ir[7]}}, ir[7:0]};

    // Field extraction and instruction classification
    always_comb begin
        fields     = '0;
        fields.rn  = ir[10:8];
        fields.rd  = ir[7:5];
        fields.rm  = ir[2:0];
        fields.op  = ir[12:11];
        fields.sh  = ir[4:3];
        case (ir[15:13])
            OPC_MOV: begin
                case (ir[12:11])
                    OP_MOVI: fields.is_movi = 1'b1;
                    OP_MOVR: fields.is_movr = 1'b1;
                    default: fields.illegal = 1'b1;
                endcase
            end
            OPC_ALU: begin
                case (ir[12:11])
                    OP_ADD:  fields.is_abin = 1'b1;
                    OP_CMP:  begin
                        fields.is_abin = 1'b1;
                        fields.is_cmp  = 1'b1;
                    end
                    OP_AND:  fields.is_abin = 1'b1;
                    OP_MVN:  fields.is_mvn  = 1'b1;
                    default: fields.illegal = 1'b1;
                endcase
            end
            default: fields.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/datapath_ctrl.sv
// Moore sequencer that latches one instruction at a time and steps the
// register-file / shifter / ALU datapath through its execution.
module datapath_ctrl
    import ctrl_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [15:0]       in,
    output logic              w,
    output logic              illegal,
    output logic [2:0]        readnum,
    output logic [2:0]        writenum,
    output logic              write,
    output logic              loada,
    output logic              loadb,
    output logic              loadc,
    output logic              loads,
    output logic              asel,
    output logic              bsel,
    output logic              vsel,
    output logic [1:0]        shift,
    output logic [1:0]        ALUop,
    output logic [DATA_W-1:0] datapath_in
);

    ctrl_state_t state_r;
    ctrl_state_t next_state_s;
    logic [15:0] ir_r;
    logic        illegal_r;
    ins_fields_t dec_s;

    ins_decoder #(.DATA_W(DATA_W)) u_dec (
        .ir      (ir_r),
        .fields  (dec_s),
        .imm_ext (datapath_in)
    );

    assign illegal = illegal_r;

    // State, instruction latch and sticky illegal flag
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= S_WAIT;
            ir_r      <= 16'h0000;
            illegal_r <= 1'b0;
        end else begin
            state_r <= next_state_s;
            if ((state_r == S_WAIT) && start) begin
                ir_r      <= in;
                illegal_r <= 1'b0;
            end else if ((state_r == S_DECODE) && dec_s.illegal) begin
                illegal_r <= 1'b1;
            end else begin
                illegal_r <= illegal_r;
            end
        end
    end

    // Next-state selection
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_WAIT: begin
                if (start) next_state_s = S_DECODE;
                else       next_state_s = S_WAIT;
            end
            S_DECODE: begin
                if (dec_s.illegal)      next_state_s = S_WAIT;
                else if (dec_s.is_movi) next_state_s = S_WR_IMM;
                else if (dec_s.is_abin) next_state_s = S_GET_A;
                else                    next_state_s = S_GET_B;
            end
            S_WR_IMM: next_state_s = S_WAIT;
            S_GET_A:  next_state_s = S_GET_B;
            S_GET_B:  next_state_s = S_EXEC;
            S_EXEC: begin
                if (dec_s.is_cmp) next_state_s = S_WAIT;
                else              next_state_s = S_WR_RES;
            end
            S_WR_RES: next_state_s = S_WAIT;
            default:  next_state_s = S_WAIT;
        endcase
    end

    // Moore datapath controls decoded from state and latched instruction
    always_comb begin
        w        = 1'b0;
        write    = 1'b0;
        loada    = 1'b0;
        loadb    = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        asel     = 1'b0;
        bsel     = 1'b0;
        vsel     = 1'b0;
        readnum  = 3'd0;
        writenum = 3'd0;
        shift    = 2'b00;
        ALUop    = 2'b00;
        case (state_r)
            S_WAIT: w = 1'b1;
            S_WR_IMM: begin
                vsel     = 1'b1;
                write    = 1'b1;
                writenum = dec_s.rn;
            end
            S_GET_A: begin
                readnum = dec_s.rn;
                loada   = 1'b1;
            end
            S_GET_B: begin
                readnum = dec_s.rm;
                loadb   = 1'b1;
            end
            S_EXEC: begin
                shift = dec_s.sh;
                asel  = dec_s.is_movr | dec_s.is_mvn;
                ALUop = dec_s.is_movr ? ALU_PASS : dec_s.op;
                if (dec_s.is_cmp) begin
                    loads = 1'b1;
                end else begin
                    loadc = 1'b1;
                end
            end
            S_WR_RES: begin
                write    = 1'b1;
                writenum = dec_s.rd;
            end
            default: w = 1'b0;
        endcase
    end

endmodule

// File: doc/datapath_ctrl.md
Name: datapath_ctrl

Overview:
- Moore FSM that sequences the 8-register / shifter / ALU `datapath` for one 16-bit instruction at a time.
- Accepts an instruction word via a start/ready handshake, decodes it, and drives every `datapath` control input cycle-by-cycle.
- Drives the sign-extended immediate onto `datapath_in`.
- Sits between the instruction source (bench now, fetch unit later) and `datapath`.

Parameters:
DATA_W, 16, width of `datapath_in` and of the sign-extended immediate (the instruction word is always 16 bits).

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
start  in  1  request to execute `in`; sampled only in WAIT
in  in  16  instruction word
w  out  1  1 = idle in WAIT and ready for `start`
illegal  out  1  last accepted instruction had an undefined encoding; held until the next accepted `start`
readnum  out  3  to datapath
writenum  out  3  to datapath
write  out  1  to datapath
loada  out  1  to datapath
loadb  out  1  to datapath
loadc  out  1  to datapath
loads  out  1  to datapath
asel  out  1  to datapath
bsel  out  1  to datapath
vsel  out  1  to datapath; 1 = select datapath_in
shift  out  2  to datapath
ALUop  out  2  to datapath
datapath_in  out  DATA_W  sign-extended imm8

Behaviour:
- Clock and reset: the single clock is `clk`; `reset` is synchronous and active-high.
- Instruction fields, taken from the latched register `ir`:
  - opcode = ir[15:13], op = ir[12:11], Rn = ir[10:8], Rd = ir[7:5], sh = ir[4:3], Rm = ir[2:0], imm8 = ir[7:0].
- Encodings:
  - 110/10 MOV Rn,#imm8
  - 110/00 MOV Rd,Rm{,sh}
  - 101/00 ADD Rd,Rn,Rm{,sh}
  - 101/01 CMP Rn,Rm{,sh}
  - 101/10 AND Rd,Rn,Rm{,sh}
  - 101/11 MVN Rd,Rm{,sh}
  - Anything else is illegal.
- `datapath_in` = sign-extension of imm8 to DATA_W, combinational from `ir`, valid in every state.
- States: WAIT, DECODE, WR_IMM, GET_A, GET_B, EXEC, WR_RES.
- Outputs are Moore, decoded from state and `ir`. Every strobe (write, loada, loadb, loadc, loads) is 0 unless listed for a state below.
- Reset: state = WAIT, `ir` = 0, illegal = 0, w = 1, all strobes 0, readnum/writenum/shift/ALUop = 0, asel = bsel = vsel = 0.
- Reset overrides `start` in the same cycle.
- Reset in any state returns to WAIT on the next edge; no `write` pulse follows it.
- WAIT:
  - w = 1.
  - If start = 1: ir <= in, illegal <= 0, go to DECODE.
  - `start` in any other state is ignored and not queued.
- DECODE, next state by instruction:
  - MOV imm -> WR_IMM.
  - MOV reg / MVN -> GET_B.
  - ADD / CMP / AND -> GET_A.
  - Illegal -> WAIT with illegal <= 1.
- WR_IMM: vsel = 1, write = 1, writenum = Rn -> WAIT.
- GET_A: readnum = Rn, loada = 1 -> GET_B.
- GET_B: readnum = Rm, loadb = 1 -> EXEC.
- EXEC:
  - shift = sh, bsel = 0.
  - asel = 1 for MOV reg and MVN; asel = 0 otherwise.
  - ALUop = 00 for MOV reg; ALUop = op for the ALU class.
  - CMP: loads = 1, loadc = 0, next state WAIT.
  - All others: loadc = 1, loads = 0, next state WR_RES.
- WR_RES: vsel = 0, write = 1, writenum = Rd -> WAIT.
- Latency (cycles from the accepting edge until w = 1 again):
  - MOV imm 2; CMP 4; MOV reg / MVN 4; ADD / AND 5; illegal 1.
- `write` is high for exactly one cycle per instruction that writes a register; `write` is never high for CMP or illegal instructions.
- Back-to-back operation: `start` may be asserted in the same cycle `w` rises; there are no idle cycles between instructions.

Decomposition:
- Package `ctrl_pkg`:
  - state enum `ctrl_state_t`
  - opcode localparams OPC_MOV = 3'b110, OPC_ALU = 3'b101
  - op codes OP_ADD, OP_CMP, OP_AND, OP_MVN, OP_MOVI = 2'b10, OP_MOVR = 2'b00
- Sub-module `ins_decoder`: combinational field extraction, sign-extend, and class/illegal flags. The FSM instantiates it on `ir`.

Test Plan:
- Reset, then start with MOV R0,#7 (0xD007):
  - Required: 2 cycles after accept, a single cycle with write = 1, vsel = 1, writenum = 0, datapath_in = 0x0007; then w = 1.
- MOV R1,#-2 (0xD1FE):
  - Required: datapath_in = 0xFFFE during the write cycle, writenum = 1.
- ADD R2,R1,R0,LSL#1 (0xA148), driven into a real `datapath` after loading R0 = 7 and R1 = 2:
  - Required: readnum sequence 1 (loada) then 0 (loadb), EXEC with shift = 01 and ALUop = 00, WR_RES with writenum = 2.
  - Required: R2 = 16, datapath_out = 16.
- CMP R3,R1,LSR#1 (0xAB11):
  - Required: loads = 1 in EXEC, write never asserted, w returns 4 cycles after accept.
- start pulsed while busy, and illegal word 0xE000:
  - Busy start: ignored, no extra writes.
  - Illegal word: illegal = 1 and w = 1 one cycle after accept; illegal clears on the next accepted start.
- ADD issued, then reset asserted in EXEC:
  - Required: next cycle state = WAIT, all strobes 0, no write pulse, destination register unchanged.
